// File: rtl/top.sv
// top: control-triggered dual i64 stream generator (S0 = index, S1 = index + OFFSET).
// Define STREAM_EOS_COUNT_EN to carry COUNT in the EOS beat data fields (else 0).
module top #(
    parameter int unsigned COUNT  = 10,
    parameter logic [63:0] OFFSET = 64'd100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inCtrl_valid,
    output logic        inCtrl_ready,
    output logic        out0_valid,
    input  logic        out0_ready,
    output logic [63:0] out0_data_field0,
    output logic        out0_data_field1,
    output logic        out1_valid,
    input  logic        out1_ready,
    output logic        out2_valid,
    input  logic        out2_ready,
    output logic [63:0] out2_data_field0,
    output logic        out2_data_field1,
    output logic        out3_valid,
    input  logic        out3_ready,
    output logic        outCtrl_valid,
    input  logic        outCtrl_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [63:0] LAST = 64'(COUNT);

`ifdef STREAM_EOS_COUNT_EN
    localparam logic [63:0] EOS_DATA = LAST;
`else
    localparam logic [63:0] EOS_DATA = 64'd0;
`endif

    state_t      state_q;
    state_t      state_d;
    logic [63:0] index_q;
    logic [63:0] index_d;

    logic emit;
    logic eos;
    logic start_xfer;
    logic beat_xfer;
    logic ctrl_xfer;

    // Handshake decode; the four stream channels only move together.
    always_comb begin
        emit       = (state_q == EMIT);
        eos        = (index_q == LAST);
        start_xfer = inCtrl_valid && inCtrl_ready;
        beat_xfer  = emit && out0_ready && out1_ready
                     && out2_ready && out3_ready;
        ctrl_xfer  = (state_q == DONE) && outCtrl_ready;
    end

    // Outputs depend on state and index only, never on a ready.
    always_comb begin
        inCtrl_ready     = (state_q == IDLE) && !reset;
        out0_valid       = emit;
        out1_valid       = emit;
        out2_valid       = emit;
        out3_valid       = emit;
        outCtrl_valid    = (state_q == DONE);
        out0_data_field0 = 64'd0;
        out0_data_field1 = 1'b0;
        out2_data_field0 = 64'd0;
        out2_data_field1 = 1'b0;
        if (emit) begin
            if (eos) begin
                out0_data_field0 = EOS_DATA;
                out2_data_field0 = EOS_DATA;
                out0_data_field1 = 1'b1;
                out2_data_field1 = 1'b1;
            end else begin
                out0_data_field0 = index_q;
                out2_data_field0 = index_q + OFFSET;
            end
        end
    end

    // Next-state: start -> beats 0..COUNT (last is EOS) -> completion token.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        unique case (state_q)
            IDLE: begin
                if (start_xfer) begin
                    state_d = EMIT;
                    index_d = 64'd0;
                end
            end
            EMIT: begin
                if (beat_xfer) begin
                    if (eos) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + 64'd1;
                    end
                end
            end
            DONE: begin
                if (ctrl_xfer) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                index_d = 64'd0;
            end
        endcase
    end

    // State registers; reset aborts any run in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            index_q <= 64'd0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

endmodule

// File: tb/tb_top.sv
// tb_top: scoreboard bench for top (COUNT=10/OFFSET=100 and a COUNT=0 instance).
// Expected beats are queued on each accepted start and popped on each transfer.
module tb_top;

    localparam int          C = 10;
    localparam logic [63:0] O = 64'd100;

`ifdef STREAM_EOS_COUNT_EN
    localparam logic [63:0] EOSV = 64'(C);
`else
    localparam logic [63:0] EOSV = 64'd0;
`endif

    typedef struct {
        logic [63:0] d0;
        logic [63:0] d2;
        logic        e;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        inCtrl_valid, inCtrl_ready;
    logic        out0_valid, out0_ready, out0_data_field1;
    logic [63:0] out0_data_field0;
    logic        out1_valid, out1_ready;
    logic        out2_valid, out2_ready, out2_data_field1;
    logic [63:0] out2_data_field0;
    logic        out3_valid, out3_ready;
    logic        outCtrl_valid, outCtrl_ready;

    logic        z_in_valid, z_in_ready;
    logic        z_v0, z_v1, z_v2, z_v3, z_e0, z_e2, z_cv;
    logic [63:0] z_d0, z_d2;
    logic        z_one;

    top #(.COUNT(C), .OFFSET(O)) dut (
        .clock(clk), .reset(reset),
        .inCtrl_valid(inCtrl_valid), .inCtrl_ready(inCtrl_ready),
        .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out0_data_field0(out0_data_field0),
        .out0_data_field1(out0_data_field1),
        .out1_valid(out1_valid), .out1_ready(out1_ready),
        .out2_valid(out2_valid), .out2_ready(out2_ready),
        .out2_data_field0(out2_data_field0),
        .out2_data_field1(out2_data_field1),
        .out3_valid(out3_valid), .out3_ready(out3_ready),
        .outCtrl_valid(outCtrl_valid), .outCtrl_ready(outCtrl_ready)
    );

    top #(.COUNT(0), .OFFSET(64'd7)) dut_z (
        .clock(clk), .reset(reset),
        .inCtrl_valid(z_in_valid), .inCtrl_ready(z_in_ready),
        .out0_valid(z_v0), .out0_ready(z_one),
        .out0_data_field0(z_d0), .out0_data_field1(z_e0),
        .out1_valid(z_v1), .out1_ready(z_one),
        .out2_valid(z_v2), .out2_ready(z_one),
        .out2_data_field0(z_d2), .out2_data_field1(z_e2),
        .out3_valid(z_v3), .out3_ready(z_one),
        .outCtrl_valid(z_cv), .outCtrl_ready(z_one)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, a, x, $time);
        end
    endtask

    task automatic timeout(input string n);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event at %0t", n, $time);
    endtask

    // ---------------- main scoreboard / monitor ----------------
    beat_t q[$];
    bit    m_idle  = 1'b1;
    bit    ctrl_due = 1'b0;
    int    runs    = 0;

    always @(negedge clk) begin
        bit    idle_now;
        beat_t e;
        idle_now = m_idle;
        if (reset) begin
            chk("rst_in_ready", {63'd0, inCtrl_ready}, 64'd0);
            q.delete();
            m_idle   = 1'b1;
            ctrl_due = 1'b0;
        end else begin
            chk("in_ready", {63'd0, inCtrl_ready}, {63'd0, idle_now});
            chk("valids",
                {60'd0, out0_valid, out1_valid, out2_valid, out3_valid},
                {60'd0, {4{q.size() != 0}}});
            chk("ctrl_valid", {63'd0, outCtrl_valid}, {63'd0, ctrl_due});
            if (ctrl_due && outCtrl_valid && outCtrl_ready) begin
                ctrl_due = 1'b0;
                m_idle   = 1'b1;
                runs++;
            end
            if (q.size() != 0 && out0_valid) begin
                e = q[0];
                chk("s0_data", out0_data_field0, e.d0);
                chk("s0_eos", {63'd0, out0_data_field1}, {63'd0, e.e});
                chk("s1_data", out2_data_field0, e.d2);
                chk("s1_eos", {63'd0, out2_data_field1}, {63'd0, e.e});
                if (out0_ready && out1_ready && out2_ready && out3_ready) begin
                    void'(q.pop_front());
                    if (e.e) ctrl_due = 1'b1;
                end
            end
            if (inCtrl_valid && idle_now) begin
                m_idle = 1'b0;
                for (int i = 0; i <= C; i++) begin
                    if (i < C) begin
                        e.d0 = 64'(i);
                        e.d2 = 64'(i) + O;
                        e.e  = 1'b0;
                    end else begin
                        e.d0 = EOSV;
                        e.d2 = EOSV;
                        e.e  = 1'b1;
                    end
                    q.push_back(e);
                end
            end
        end
    end

    // ---------------- COUNT=0 instance monitor ----------------
    bit z_idle = 1'b1;
    bit z_pend = 1'b0;
    bit z_ctrl = 1'b0;
    int z_runs = 0;

    always @(negedge clk) begin
        bit idle_now;
        idle_now = z_idle;
        if (reset) begin
            z_idle = 1'b1;
            z_pend = 1'b0;
            z_ctrl = 1'b0;
        end else begin
            chk("z_in_ready", {63'd0, z_in_ready}, {63'd0, idle_now});
            chk("z_valids", {60'd0, z_v0, z_v1, z_v2, z_v3},
                {60'd0, {4{z_pend}}});
            chk("z_ctrl_valid", {63'd0, z_cv}, {63'd0, z_ctrl});
            if (z_ctrl && z_cv) begin
                z_ctrl = 1'b0;
                z_idle = 1'b1;
                z_runs++;
            end
            if (z_pend && z_v0) begin
                chk("z_s0_eos", {63'd0, z_e0}, 64'd1);
                chk("z_s1_eos", {63'd0, z_e2}, 64'd1);
                chk("z_s0_data", z_d0, 64'd0);
                chk("z_s1_data", z_d2, 64'd0);
                z_pend = 1'b0;
                z_ctrl = 1'b1;
            end
            if (z_in_valid && idle_now) begin
                z_idle = 1'b0;
                z_pend = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_readies(input bit v);
        out0_ready = v;
        out1_ready = v;
        out2_ready = v;
        out3_ready = v;
    endtask

    task automatic start();
        bit ok;
        ok = 1'b0;
        inCtrl_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (inCtrl_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) timeout("start");
        tick();
        inCtrl_valid = 1'b0;
    endtask

    task automatic wait_runs(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (runs >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) timeout("wait_runs");
    endtask

    task automatic wait_beat(input int idx);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out0_valid && !out0_data_field1
                && out0_data_field0 == 64'(idx)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) timeout("wait_beat");
    endtask

    initial begin
        int cyc;
        bit ok;
        reset         = 1'b1;
        inCtrl_valid  = 1'b1;
        z_in_valid    = 1'b0;
        z_one         = 1'b1;
        outCtrl_ready = 1'b1;
        set_readies(1'b1);

        // reset with a start pending, then one start cycle
        tick();
        reset = 1'b0;
        tick();
        inCtrl_valid = 1'b0;
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            if (out0_valid) cyc++;
            else if (cyc > 0) break;
            tick();
        end
        chk("run1_beat_cycles", 64'(cyc), 64'(C + 1));
        wait_runs(1);
        repeat (5) tick();
        chk("single_run", 64'(runs), 64'd1);

        // S1 data channel stalled during beat 4
        start();
        wait_beat(4);
        out2_ready = 1'b0;
        repeat (3) tick();
        out2_ready = 1'b1;
        wait_runs(2);

        // COUNT=0 instance: EOS first, then completion
        z_in_valid = 1'b1;
        tick();
        z_in_valid = 1'b0;
        repeat (4) tick();
        chk("z_runs", 64'(z_runs), 64'd1);

        // completion token backpressure, then back-to-back start
        outCtrl_ready = 1'b0;
        start();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (outCtrl_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) timeout("ctrl_wait");
        inCtrl_valid = 1'b1;
        repeat (5) begin
            tick();
            chk("ctrl_held", {63'd0, outCtrl_valid}, 64'd1);
            chk("in_ready_done", {63'd0, inCtrl_ready}, 64'd0);
        end
        outCtrl_ready = 1'b1;
        start();
        wait_runs(4);

        // random backpressure on all channels
        for (int r = 0; r < 3; r++) begin
            start();
            for (int i = 0; i < 400 && runs < 5 + r; i++) begin
                out0_ready    = 1'($urandom_range(0, 3) != 0);
                out1_ready    = 1'($urandom_range(0, 3) != 0);
                out2_ready    = 1'($urandom_range(0, 3) != 0);
                out3_ready    = 1'($urandom_range(0, 3) != 0);
                outCtrl_ready = 1'($urandom_range(0, 1));
                tick();
            end
            set_readies(1'b1);
            outCtrl_ready = 1'b1;
            wait_runs(5 + r);
        end

        // reset at beat 6 aborts the run
        start();
        wait_beat(6);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_valids",
            {59'd0, out0_valid, out1_valid, out2_valid, out3_valid,
             outCtrl_valid}, 64'd0);
        chk("rst_in_ready_low", {63'd0, inCtrl_ready}, 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", {63'd0, inCtrl_ready}, 64'd1);
        repeat (15) tick();
        chk("abort_no_ctrl", 64'(runs), 64'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
